skin_div_arbiter: RTL and testbench

- Shares one pipelined divider core between the trans_cb and trans_cr transform datapaths of the skin-tone detector.
- Arbitrates requests round-robin, drives divider operands, and tags each issued operation with requester id and a zero-divisor flag.
- Routes each returning quotient/fraction to the requester that issued it.
- Sits between the two transform blocks and the single divider instance; the divider's rfd gates issue.

---
 rtl/skin_div_arbiter.sv | 138 +++++++++++++
 tb/tb_skin_div_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/skin_div_arbiter.sv
// Round-robin arbiter sharing one pipelined divider between the Cb and Cr transforms.
// Each issued operation carries a {valid, id, dbz} tag that steers the returning result.
module skin_div_arbiter #(
    parameter int DIVIDEND_W  = 24,
    parameter int DIVISOR_W   = 16,
    parameter int FRAC_W      = 8,
    parameter int DIV_LATENCY = 28
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cb_req_valid,
    output logic                  cb_req_ready,
    input  logic [DIVIDEND_W-1:0] cb_dividend,
    input  logic [DIVISOR_W-1:0]  cb_divisor,
    input  logic                  cr_req_valid,
    output logic                  cr_req_ready,
    input  logic [DIVIDEND_W-1:0] cr_dividend,
    input  logic [DIVISOR_W-1:0]  cr_divisor,
    input  logic                  div_rfd,
    output logic [DIVIDEND_W-1:0] div_dividend,
    output logic [DIVISOR_W-1:0]  div_divisor,
    input  logic [DIVIDEND_W-1:0] div_quotient,
    input  logic [FRAC_W-1:0]     div_fractional,
    output logic                  cb_res_valid,
    output logic [DIVIDEND_W-1:0] cb_res_quotient,
    output logic [FRAC_W-1:0]     cb_res_fractional,
    output logic                  cb_res_dbz,
    output logic                  cr_res_valid,
    output logic [DIVIDEND_W-1:0] cr_res_quotient,
    output logic [FRAC_W-1:0]     cr_res_fractional,
    output logic                  cr_res_dbz,
    output logic                  idle
);

    typedef enum logic {PTR_CB = 1'b0, PTR_CR = 1'b1} ptr_t;

    typedef struct packed {
        logic valid;
        logic id;
        logic dbz;
    } tag_t;

    ptr_t                  r_ptr;
    ptr_t                  w_ptr_next;
    logic                  w_cb_grant;
    logic                  w_cr_grant;
    logic                  w_grant;
    logic                  w_dbz;
    logic [DIVIDEND_W-1:0] w_dividend;
    logic [DIVISOR_W-1:0]  w_divisor;
    logic                  w_busy;
    tag_t                  w_ret;
    tag_t                  r_issue;
    tag_t                  r_tag [0:DIV_LATENCY];

    assign cb_req_ready = div_rfd & (~cr_req_valid | (r_ptr == PTR_CB));
    assign cr_req_ready = div_rfd & (~cb_req_valid | (r_ptr == PTR_CR));
    assign w_cb_grant   = cb_req_valid & cb_req_ready;
    assign w_cr_grant   = cr_req_valid & cr_req_ready;
    assign w_grant      = w_cb_grant | w_cr_grant;
    assign w_ret        = r_tag[DIV_LATENCY];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_ptr <= PTR_CB;
        else     r_ptr <= w_ptr_next;
    end

    always_comb begin
        w_ptr_next = r_ptr;
        w_dividend = cb_dividend;
        w_divisor  = cb_divisor;
        if (w_cb_grant) begin
            w_ptr_next = PTR_CR;
        end else if (w_cr_grant) begin
            w_ptr_next = PTR_CB;
            w_dividend = cr_dividend;
            w_divisor  = cr_divisor;
        end
        w_dbz = (w_divisor == '0);
    end

    // Zero divisors issue 0/1 so the core never sees an undefined operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_dividend <= '0;
            div_divisor  <= '0;
        end else if (w_grant) begin
            div_dividend <= w_dbz ? '0 : w_dividend;
            div_divisor  <= w_dbz ? DIVISOR_W'(1) : w_divisor;
        end
    end

    // Issue tag sits beside the operand register; the core captures one edge later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_issue <= '0;
            for (int unsigned i = 0; i <= DIV_LATENCY; i++) r_tag[i] <= '0;
        end else begin
            r_issue  <= '{valid: w_grant, id: w_cr_grant, dbz: w_dbz};
            r_tag[0] <= r_issue;
            for (int unsigned i = 1; i <= DIV_LATENCY; i++) r_tag[i] <= r_tag[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cb_res_valid      <= 1'b0;
            cb_res_quotient   <= '0;
            cb_res_fractional <= '0;
            cb_res_dbz        <= 1'b0;
            cr_res_valid      <= 1'b0;
            cr_res_quotient   <= '0;
            cr_res_fractional <= '0;
            cr_res_dbz        <= 1'b0;
        end else begin
            cb_res_valid <= w_ret.valid & ~w_ret.id;
            cr_res_valid <= w_ret.valid & w_ret.id;
            if (w_ret.valid & ~w_ret.id) begin
                cb_res_quotient   <= w_ret.dbz ? '1 : div_quotient;
                cb_res_fractional <= w_ret.dbz ? '0 : div_fractional;
                cb_res_dbz        <= w_ret.dbz;
            end
            if (w_ret.valid & w_ret.id) begin
                cr_res_quotient   <= w_ret.dbz ? '1 : div_quotient;
                cr_res_fractional <= w_ret.dbz ? '0 : div_fractional;
                cr_res_dbz        <= w_ret.dbz;
            end
        end
    end

    always_comb begin
        w_busy = r_issue.valid | cb_res_valid | cr_res_valid;
        for (int unsigned i = 0; i <= DIV_LATENCY; i++) w_busy = w_busy | r_tag[i].valid;
    end

    assign idle = ~cb_req_valid & ~cr_req_valid & ~w_busy;

endmodule

// File: tb/tb_skin_div_arbiter.sv
// Directed bench for skin_div_arbiter with a behavioural divider core model.
module tb_skin_div_arbiter;

    localparam int L = 28;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cb_req_valid = 1'b0, cr_req_valid = 1'b0;
    logic        cb_req_ready, cr_req_ready;
    logic [23:0] cb_dividend = '0, cr_dividend = '0;
    logic [15:0] cb_divisor = '0, cr_divisor = '0;
    logic        div_rfd = 1'b1;
    logic [23:0] div_dividend, div_quotient;
    logic [15:0] div_divisor;
    logic [7:0]  div_fractional;
    logic        cb_res_valid, cb_res_dbz, cr_res_valid, cr_res_dbz;
    logic [23:0] cb_res_quotient, cr_res_quotient;
    logic [7:0]  cb_res_fractional, cr_res_fractional;
    logic        idle;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;
    int unsigned cyc = 0;

    skin_div_arbiter #(.DIVIDEND_W(24), .DIVISOR_W(16), .FRAC_W(8), .DIV_LATENCY(L)) dut (
        .clk(clk), .rst(rst),
        .cb_req_valid(cb_req_valid), .cb_req_ready(cb_req_ready),
        .cb_dividend(cb_dividend), .cb_divisor(cb_divisor),
        .cr_req_valid(cr_req_valid), .cr_req_ready(cr_req_ready),
        .cr_dividend(cr_dividend), .cr_divisor(cr_divisor),
        .div_rfd(div_rfd), .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_quotient(div_quotient), .div_fractional(div_fractional),
        .cb_res_valid(cb_res_valid), .cb_res_quotient(cb_res_quotient),
        .cb_res_fractional(cb_res_fractional), .cb_res_dbz(cb_res_dbz),
        .cr_res_valid(cr_res_valid), .cr_res_quotient(cr_res_quotient),
        .cr_res_fractional(cr_res_fractional), .cr_res_dbz(cr_res_dbz),
        .idle(idle)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [23:0] rq(input logic [23:0] dd, input logic [15:0] ds);
        return (ds == 16'd0) ? 24'd0 : dd / {8'd0, ds};
    endfunction

    function automatic logic [7:0] rf(input logic [23:0] dd, input logic [15:0] ds);
        logic [31:0] r;
        if (ds == 16'd0) return 8'd0;
        r = {8'd0, dd} % {16'd0, ds};
        return 8'(((r << 8) / {16'd0, ds}));
    endfunction

    // Divider core: captures operands every edge, result valid L edges after capture.
    logic [23:0] mq [0:L];
    logic [7:0]  mf [0:L];
    always @(posedge clk) begin
        for (int i = L; i > 0; i--) begin
            mq[i] <= mq[i-1];
            mf[i] <= mf[i-1];
        end
        mq[0] <= rq(div_dividend, div_divisor);
        mf[0] <= rf(div_dividend, div_divisor);
    end
    assign div_quotient   = mq[L];
    assign div_fractional = mf[L];

    typedef struct {
        logic [23:0] q;
        logic [7:0]  f;
        logic        dbz;
        int unsigned t;
    } res_t;
    res_t cb_got[$];
    res_t cr_got[$];

    always @(negedge clk) begin
        if (!rst && cb_res_valid) cb_got.push_back('{cb_res_quotient, cb_res_fractional, cb_res_dbz, cyc});
        if (!rst && cr_res_valid) cr_got.push_back('{cr_res_quotient, cr_res_fractional, cr_res_dbz, cyc});
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        id;
        logic [23:0] dd;
        logic [15:0] ds;
        logic [23:0] eq;
        logic [7:0]  ef;
        logic        edbz;
    } vec_t;
    vec_t vecs [7];

    initial begin
        int unsigned acc;
        res_t r;
        vecs[0] = '{1'b0, 24'd1000,    16'd8,  24'd125,     8'd0,   1'b0};
        vecs[1] = '{1'b1, 24'd500,     16'd0,  24'hFFFFFF,  8'd0,   1'b1};
        vecs[2] = '{1'b0, 24'd1000,    16'd3,  24'd333,     8'd85,  1'b0};
        vecs[3] = '{1'b1, 24'h123456,  16'h10, 24'h012345,  8'd96,  1'b0};
        vecs[4] = '{1'b1, 24'd7,       16'd2,  24'd3,       8'd128, 1'b0};
        vecs[5] = '{1'b0, 24'hFFFFFF,  16'd1,  24'hFFFFFF,  8'd0,   1'b0};
        vecs[6] = '{1'b0, 24'd0,       16'd0,  24'hFFFFFF,  8'd0,   1'b1};

        #2;
        chk("rst_idle", idle, 1);
        chk("rst_cb_res_valid", cb_res_valid, 0);
        chk("rst_cr_res_valid", cr_res_valid, 0);
        chk("rst_div_dividend", div_dividend, 0);
        chk("rst_div_divisor", div_divisor, 0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // Single operations, one per vector
        for (int v = 0; v < 7; v++) begin
            cb_got.delete(); cr_got.delete();
            chk("vec_idle_before", idle, 1);
            if (vecs[v].id) begin
                cr_req_valid = 1'b1; cr_dividend = vecs[v].dd; cr_divisor = vecs[v].ds;
            end else begin
                cb_req_valid = 1'b1; cb_dividend = vecs[v].dd; cb_divisor = vecs[v].ds;
            end
            @(negedge clk);
            chk("vec_ready", vecs[v].id ? cr_req_ready : cb_req_ready, 1);
            @(posedge clk); #1;
            acc = cyc;
            cb_req_valid = 1'b0; cr_req_valid = 1'b0;
            @(negedge clk);
            chk("vec_div_dividend", div_dividend, vecs[v].edbz ? 24'd0 : vecs[v].dd);
            chk("vec_div_divisor", div_divisor, vecs[v].edbz ? 16'd1 : vecs[v].ds);
            chk("vec_idle_busy", idle, 0);
            repeat (L + 6) @(negedge clk);
            chk("vec_own_count", vecs[v].id ? cr_got.size() : cb_got.size(), 1);
            chk("vec_other_count", vecs[v].id ? cb_got.size() : cr_got.size(), 0);
            if (vecs[v].id ? (cr_got.size() > 0) : (cb_got.size() > 0)) begin
                r = vecs[v].id ? cr_got[0] : cb_got[0];
                chk("vec_latency", r.t, acc + L + 2);
                chk("vec_quotient", r.q, vecs[v].eq);
                chk("vec_fractional", r.f, vecs[v].ef);
                chk("vec_dbz", r.dbz, vecs[v].edbz);
            end
            tick();
        end

        // Round-robin alternation from a fresh pointer
        rst = 1'b1; tick(); rst = 1'b0; tick();
        cb_got.delete(); cr_got.delete();
        for (int k = 0; k < 6; k++) begin
            cb_req_valid = 1'b1; cb_dividend = 24'(100 * (k + 1)); cb_divisor = 16'd7;
            cr_req_valid = 1'b1; cr_dividend = 24'(50 * (k + 1) + 1); cr_divisor = 16'd3;
            @(negedge clk);
            chk("alt_cb_ready", cb_req_ready, (k % 2) == 0);
            chk("alt_cr_ready", cr_req_ready, (k % 2) == 1);
            @(posedge clk); #1;
            if (k == 0) acc = cyc;
        end
        cb_req_valid = 1'b0; cr_req_valid = 1'b0;
        repeat (L + 8) @(negedge clk);
        chk("alt_cb_count", cb_got.size(), 3);
        chk("alt_cr_count", cr_got.size(), 3);
        for (int j = 0; j < 3; j++) begin
            if (cb_got.size() > j) begin
                chk("alt_cb_time", cb_got[j].t, acc + L + 2 + 2 * j);
                chk("alt_cb_q", cb_got[j].q, rq(24'(100 * (2 * j + 1)), 16'd7));
                chk("alt_cb_f", cb_got[j].f, rf(24'(100 * (2 * j + 1)), 16'd7));
            end
            if (cr_got.size() > j) begin
                chk("alt_cr_time", cr_got[j].t, acc + L + 3 + 2 * j);
                chk("alt_cr_q", cr_got[j].q, rq(24'(50 * (2 * j + 2) + 1), 16'd3));
                chk("alt_cr_f", cr_got[j].f, rf(24'(50 * (2 * j + 2) + 1), 16'd3));
            end
        end

        // div_rfd low stalls both; pointer still at Cb afterwards
        tick();
        cb_got.delete(); cr_got.delete();
        div_rfd = 1'b0;
        cb_req_valid = 1'b1; cb_dividend = 24'd900; cb_divisor = 16'd30;
        cr_req_valid = 1'b1; cr_dividend = 24'd800; cr_divisor = 16'd20;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_cb_ready", cb_req_ready, 0);
            chk("stall_cr_ready", cr_req_ready, 0);
            chk("stall_idle", idle, 0);
            @(posedge clk); #1;
        end
        div_rfd = 1'b1;
        @(negedge clk);
        chk("unstall_cb_ready", cb_req_ready, 1);
        chk("unstall_cr_ready", cr_req_ready, 0);
        @(posedge clk); #1;
        acc = cyc;
        cb_req_valid = 1'b0; cr_req_valid = 1'b0;
        repeat (L + 8) @(negedge clk);
        chk("unstall_cb_count", cb_got.size(), 1);
        chk("unstall_cr_count", cr_got.size(), 0);
        if (cb_got.size() > 0) begin
            chk("unstall_time", cb_got[0].t, acc + L + 2);
            chk("unstall_q", cb_got[0].q, 24'd30);
        end

        // Reset with three operations in flight
        tick();
        cb_got.delete(); cr_got.delete();
        for (int k = 0; k < 3; k++) begin
            cb_req_valid = 1'b1; cb_dividend = 24'(5000 + k); cb_divisor = 16'd9;
            tick();
        end
        cb_req_valid = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        #1;
        chk("midrst_div_dividend", div_dividend, 0);
        chk("midrst_div_divisor", div_divisor, 0);
        chk("midrst_cb_res_q", cb_res_quotient, 0);
        chk("midrst_cb_res_valid", cb_res_valid, 0);
        chk("midrst_idle", idle, 1);
        tick();
        rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("midrst_cb_count", cb_got.size(), 0);
        chk("midrst_cr_count", cr_got.size(), 0);
        chk("midrst_idle_after", idle, 1);

        // Back-to-back Cb-only stream
        tick();
        cb_got.delete(); cr_got.delete();
        for (int k = 0; k < 4; k++) begin
            logic [23:0] dds [4];
            logic [15:0] dss [4];
            dds = '{24'd1000, 24'd12345, 24'd77, 24'hABCDE};
            dss = '{16'd8, 16'd100, 16'd9, 16'h321};
            cb_req_valid = 1'b1; cb_dividend = dds[k]; cb_divisor = dss[k];
            @(posedge clk); #1;
            if (k == 0) acc = cyc;
        end
        cb_req_valid = 1'b0;
        repeat (L + 8) @(negedge clk);
        chk("b2b_cb_count", cb_got.size(), 4);
        chk("b2b_cr_count", cr_got.size(), 0);
        if (cb_got.size() == 4) begin
            chk("b2b_t0", cb_got[0].t, acc + L + 2);
            chk("b2b_t3", cb_got[3].t, acc + L + 5);
            chk("b2b_q0", cb_got[0].q, 24'd125);
            chk("b2b_q1", cb_got[1].q, 24'd123);
            chk("b2b_f1", cb_got[1].f, 8'd115);
            chk("b2b_q2", cb_got[2].q, 24'd8);
            chk("b2b_f2", cb_got[2].f, 8'd142);
            chk("b2b_q3", cb_got[3].q, 24'd878);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
